// File: rtl/midi_voice_allocator.sv
// N-voice MIDI note allocator: parses Note On/Off and All Notes Off (with running status)
// and drives per-voice gate/note/velocity. Define MIDI_VOICE_STEAL_EN to steal the oldest voice when full.
module midi_voice_allocator #(
  parameter int NUM_VOICES   = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter int OMNI         = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [7*NUM_VOICES-1:0]         voice_note,
  output logic [7*NUM_VOICES-1:0]         voice_velocity,
  output logic                            event_valid,
  output logic [$clog2(NUM_VOICES)-1:0]   event_voice
);

  localparam int VW = $clog2(NUM_VOICES);
  typedef logic [VW-1:0] idx_t;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
  typedef enum logic [1:0] {NOTE_OFF, NOTE_ON, CTRL} msg_t;

  state_t                  state_q, state_d;
  msg_t                    msgType_q, msgType_d;
  logic [6:0]              d1_q, d1_d;
  logic                    dispatch;
  logic                    chanOk;
  logic [6:0]              d2;

  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [6:0]              note_q [NUM_VOICES];
  logic [6:0]              note_d [NUM_VOICES];
  logic [6:0]              vel_q  [NUM_VOICES];
  logic [6:0]              vel_d  [NUM_VOICES];
  idx_t                    rank_q [NUM_VOICES];
  idx_t                    rank_d [NUM_VOICES];
  logic                    evValid_q, evValid_d;
  idx_t                    evVoice_q, evVoice_d;

  logic                    hit, freeFound, alloc;
  idx_t                    hitIdx, freeIdx, target;
`ifdef MIDI_VOICE_STEAL_EN
  idx_t                    oldestIdx;
`endif

  assign chanOk = (OMNI != 0) || (rx_data[3:0] == 4'(MIDI_CHANNEL));
  assign d2     = rx_data[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      msgType_q <= NOTE_OFF;
      d1_q      <= '0;
    end else begin
      state_q   <= state_d;
      msgType_q <= msgType_d;
      d1_q      <= d1_d;
    end
  end

  // Realtime bytes (F8-FF) leave the parser untouched; any other status either latches or aborts.
  always_comb begin
    state_d   = state_q;
    msgType_d = msgType_q;
    d1_d      = d1_q;
    dispatch  = 1'b0;
    if (rx_valid) begin
      if (rx_data[7]) begin
        if (rx_data[7:3] != 5'b11111) begin
          if (chanOk && rx_data[7:4] == 4'h8) begin
            msgType_d = NOTE_OFF;
            state_d   = WAIT_D1;
          end else if (chanOk && rx_data[7:4] == 4'h9) begin
            msgType_d = NOTE_ON;
            state_d   = WAIT_D1;
          end else if (chanOk && rx_data[7:4] == 4'hB) begin
            msgType_d = CTRL;
            state_d   = WAIT_D1;
          end else begin
            state_d   = IDLE;
          end
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d    = rx_data[6:0];
            state_d = WAIT_D2;
          end
          WAIT_D2: begin
            dispatch = 1'b1;
            state_d  = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  // The second data byte is consumed directly from rx_data so the dispatch lands on the same edge.
  always_comb begin
    gate_d    = gate_q;
    note_d    = note_q;
    vel_d     = vel_q;
    rank_d    = rank_q;
    evValid_d = 1'b0;
    evVoice_d = evVoice_q;
    hit       = 1'b0;
    hitIdx    = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    alloc     = 1'b0;
    target    = '0;
`ifdef MIDI_VOICE_STEAL_EN
    oldestIdx = '0;
`endif

    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (gate_q[v] && note_q[v] == d1_q) begin
        hit    = 1'b1;
        hitIdx = idx_t'(v);
      end
      if (!gate_q[v]) begin
        freeFound = 1'b1;
        freeIdx   = idx_t'(v);
      end
`ifdef MIDI_VOICE_STEAL_EN
      if (rank_q[v] == idx_t'(NUM_VOICES - 1)) oldestIdx = idx_t'(v);
`endif
    end

    if (dispatch && msgType_q == NOTE_ON && d2 != 7'd0) begin
      if (hit) begin
        alloc  = 1'b1;
        target = hitIdx;
      end else if (freeFound) begin
        alloc  = 1'b1;
        target = freeIdx;
      end
`ifdef MIDI_VOICE_STEAL_EN
      else begin
        alloc  = 1'b1;
        target = oldestIdx;
      end
`endif
    end else if (dispatch && msgType_q != CTRL) begin
      if (hit) begin
        gate_d[hitIdx] = 1'b0;
        evValid_d      = 1'b1;
        evVoice_d      = hitIdx;
      end
    end else if (dispatch && d1_q == 7'd123) begin
      gate_d    = '0;
      evValid_d = 1'b1;
      evVoice_d = '0;
    end

    if (alloc) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (rank_q[v] < rank_q[target]) rank_d[v] = idx_t'(rank_q[v] + 1'b1);
      end
      rank_d[target] = '0;
      note_d[target] = d1_q;
      vel_d[target]  = d2;
      gate_d[target] = 1'b1;
      evValid_d      = 1'b1;
      evVoice_d      = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q    <= '0;
      evValid_q <= 1'b0;
      evVoice_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        rank_q[v] <= idx_t'(v);
      end
    end else begin
      gate_q    <= gate_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      rank_q    <= rank_d;
      evValid_q <= evValid_d;
      evVoice_q <= evVoice_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]     = note_q[g];
    assign voice_velocity[7*g +: 7] = vel_q[g];
  end

  assign voice_gate  = gate_q;
  assign event_valid = evValid_q;
  assign event_voice = evVoice_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator: directed MIDI byte streams push expected events,
// a monitor pops and compares them whenever event_valid is seen.
module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic [NV-1:0]         voice_gate;
  logic [7*NV-1:0]       voice_note;
  logic [7*NV-1:0]       voice_velocity;
  logic                  event_valid;
  logic [$clog2(NV)-1:0] event_voice;

  typedef struct {
    logic       allOff;
    int         voice;
    logic       gate;
    logic [6:0] note;
    logic [6:0] vel;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  midi_voice_allocator #(.NUM_VOICES(NV), .MIDI_CHANNEL(0), .OMNI(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .voice_gate     (voice_gate),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .event_valid    (event_valid),
    .event_voice    (event_voice)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expectEvent(input int voice, input logic gate, input logic [6:0] note, input logic [6:0] vel);
    exp_t e;
    e.allOff = 1'b0;
    e.voice  = voice;
    e.gate   = gate;
    e.note   = note;
    e.vel    = vel;
    expQ.push_back(e);
  endtask

  task automatic expectAllOff();
    exp_t e;
    e.allOff = 1'b1;
    e.voice  = 0;
    e.gate   = 1'b0;
    e.note   = '0;
    e.vel    = '0;
    expQ.push_back(e);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every event pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (event_valid) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_event: got event on voice %0d, required none", event_voice);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_voice", 32'(event_voice), 32'(e.voice));
          if (e.allOff) begin
            checkOutput("all_off_gates", 32'(voice_gate), 32'd0);
          end else begin
            checkOutput("event_gate", 32'(voice_gate[e.voice]), 32'(e.gate));
            checkOutput("event_note", 32'(voice_note[7*e.voice +: 7]), 32'(e.note));
            checkOutput("event_velocity", 32'(voice_velocity[7*e.voice +: 7]), 32'(e.vel));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut();
    checkOutput("reset_gate", 32'(voice_gate), 32'd0);
    checkOutput("reset_note", 32'(voice_note), 32'd0);
    checkOutput("reset_velocity", 32'(voice_velocity), 32'd0);
    checkOutput("reset_event_valid", 32'(event_valid), 32'd0);
    checkOutput("reset_event_voice", 32'(event_voice), 32'd0);

    // Allocation and release
    expectEvent(0, 1'b1, 7'h3C, 7'h64);
    send3(8'h90, 8'h3C, 8'h64);
    idle(3);
    expectEvent(0, 1'b0, 7'h3C, 7'h64);
    send3(8'h80, 8'h3C, 8'h00);
    idle(3);
    checkOutput("release_gate", 32'(voice_gate), 32'd0);
    checkOutput("release_note_kept", 32'(voice_note[6:0]), 32'h3C);
    checkQuiet("alloc_pending");

    // Running status, back-to-back bytes, velocity-0 off
    resetDut();
    expectEvent(0, 1'b1, 7'h3C, 7'h40);
    expectEvent(1, 1'b1, 7'h3E, 7'h40);
    expectEvent(2, 1'b1, 7'h40, 7'h40);
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    applyStimulus(8'h40);
    applyStimulus(8'h3E);
    applyStimulus(8'h40);
    applyStimulus(8'h40);
    applyStimulus(8'h40);
    expectEvent(1, 1'b0, 7'h3E, 7'h40);
    applyStimulus(8'h3E);
    applyStimulus(8'h00);
    idle(3);
    checkOutput("running_gates", 32'(voice_gate), 32'h5);
    checkQuiet("running_pending");

    // Channel filter, realtime inside a message, aborted message
    resetDut();
    send3(8'h91, 8'h3C, 8'h40);
    idle(3);
    checkOutput("filter_gate", 32'(voice_gate), 32'd0);
    expectEvent(0, 1'b1, 7'h3C, 7'h40);
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    applyStimulus(8'hF8);
    applyStimulus(8'h40);
    idle(3);
    applyStimulus(8'h90);
    applyStimulus(8'h3E);
    applyStimulus(8'hC0);
    applyStimulus(8'h40);
    idle(3);
    checkOutput("abort_gate", 32'(voice_gate), 32'h1);
    checkQuiet("filter_pending");

    // Voice pool full
    resetDut();
    expectEvent(0, 1'b1, 7'h30, 7'h10);
    expectEvent(1, 1'b1, 7'h31, 7'h10);
    expectEvent(2, 1'b1, 7'h32, 7'h10);
    expectEvent(3, 1'b1, 7'h33, 7'h10);
    applyStimulus(8'h90);
    applyStimulus(8'h30);
    applyStimulus(8'h10);
    applyStimulus(8'h31);
    applyStimulus(8'h10);
    applyStimulus(8'h32);
    applyStimulus(8'h10);
    applyStimulus(8'h33);
    applyStimulus(8'h10);
    idle(3);
`ifdef MIDI_VOICE_STEAL_EN
    expectEvent(0, 1'b1, 7'h34, 7'h50);
    send3(8'h90, 8'h34, 8'h50);
    idle(3);
    checkOutput("steal_gates", 32'(voice_gate), 32'hF);
    checkOutput("steal_note", 32'(voice_note[6:0]), 32'h34);
`else
    send3(8'h90, 8'h34, 8'h50);
    idle(3);
    checkOutput("full_gates", 32'(voice_gate), 32'hF);
    checkOutput("full_notes", 32'(voice_note), 32'({7'h33, 7'h32, 7'h31, 7'h30}));
    send3(8'h80, 8'h34, 8'h00);
    idle(3);
    checkOutput("full_off_gates", 32'(voice_gate), 32'hF);
`endif
    checkQuiet("full_pending");

    // Retrigger, ignored CC, All Notes Off
    resetDut();
    expectEvent(0, 1'b1, 7'h30, 7'h10);
    send3(8'h90, 8'h30, 8'h10);
    expectEvent(0, 1'b1, 7'h30, 7'h7F);
    send3(8'h90, 8'h30, 8'h7F);
    idle(3);
    checkOutput("retrig_gates", 32'(voice_gate), 32'h1);
    send3(8'hB0, 8'h07, 8'h64);
    idle(3);
    expectAllOff();
    send3(8'hB0, 8'h7B, 8'h00);
    idle(3);
    checkOutput("alloff_gates", 32'(voice_gate), 32'd0);
    checkOutput("alloff_velocity", 32'(voice_velocity[6:0]), 32'h7F);
    checkQuiet("alloff_pending");

    // Asynchronous reset in the middle of a message
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    @(negedge clk);
    rx_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    applyStimulus(8'h40);
    idle(3);
    checkOutput("midreset_gates", 32'(voice_gate), 32'd0);
    expectEvent(0, 1'b1, 7'h3C, 7'h40);
    send3(8'h90, 8'h3C, 8'h40);
    idle(3);
    checkQuiet("midreset_pending");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
